// File: rtl/slt_pkg.sv
// Shared types and defaults for the multi-cycle SLT/SLTU compare sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package slt_pkg;

  // Sequencer control states: waiting, scanning digits, reporting result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and digit width (bits examined per cycle).
  localparam int XLEN_DEF  = 32;
  localparam int DIGIT_DEF = 4;

  // Number of digits an operand is split into; the scan length on a tie.
  function automatic int digits(input int xlen, input int digit);
    return xlen / digit;
  endfunction

endpackage

// File: rtl/slt_sequencer_digit_compare.sv
// Unsigned compare of one DIGIT-wide slice of each operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             lt
);

  // Equality decides whether the scan continues; lt is only consumed when eq=0
  // or on the final digit, where a tie correctly yields lt=0.
  always_comb begin
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/slt_sequencer.sv
// MSB-first digit-serial less-than for SLT/SLTI/SLTU/SLTIU, result zero-extended.
// Latency: done 1+k cycles after start, k = position of first differing digit (max XLEN/DIGIT).
// Backpressure: start is sampled only while busy=0; starts during a scan are dropped, not queued.
module slt_sequencer
  import slt_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op_unsigned,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int NDIG = digits(XLEN, DIGIT);
  // Keep the index at least one bit wide so a single-digit build still elaborates.
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  // Width of the bit offset of a digit inside an operand.
  localparam int SW   = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  // A digit width that does not tile the operand would leave bits unscanned.
  if ((XLEN % DIGIT) != 0) begin : g_bad_digit
    $error("slt_sequencer: DIGIT (%0d) must divide XLEN (%0d)", DIGIT, XLEN);
  end

  state_t            state_q;
  state_t            state_d;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [IW-1:0]     idx_q;
  logic              lt_q;

  logic              accept;
  logic              scan_end;
  logic [SW-1:0]     sel_lsb;
  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;
  logic              dig_eq;
  logic              dig_lt;

  // A new request is taken whenever no scan is in flight, including the DONE
  // cycle, so back-to-back operations need no idle bubble.
  assign accept = start && (state_q != SCAN);

  // Scan finishes on the first differing digit or after the least significant one.
  assign scan_end = !dig_eq || (idx_q == '0);

  // Select the current digit of each operand, walking from the MSB down.
  assign sel_lsb = SW'(idx_q) * SW'(DIGIT);
  assign a_dig   = a_q[sel_lsb +: DIGIT];
  assign b_dig   = b_q[sel_lsb +: DIGIT];

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .a  (a_dig),
    .b  (b_dig),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE behaves like IDLE for accepting new work.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SCAN : IDLE;
      SCAN:    state_d = scan_end ? DONE : SCAN;
      DONE:    state_d = accept ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing flows combinationally from inputs.
  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  // Operand capture and digit index. Flipping the sign bit of both operands for
  // signed ops maps two's-complement order onto plain unsigned order, so the
  // datapath only ever performs unsigned digit compares.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
    end else if (accept) begin
      a_q   <= {rs1[XLEN-1] ^ ~op_unsigned, rs1[XLEN-2:0]};
      b_q   <= {rs2[XLEN-1] ^ ~op_unsigned, rs2[XLEN-2:0]};
      idx_q <= LAST_IDX;
    end else if ((state_q == SCAN) && !scan_end) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  // Result flag is written only when a scan completes; a fresh start leaves the
  // previous answer visible until the new one is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      lt_q <= 1'b0;
    end else if ((state_q == SCAN) && scan_end) begin
      lt_q <= dig_lt;
    end
  end

  assign result = {{(XLEN-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_slt_sequencer.sv
module tb_slt_sequencer;

  localparam int XLEN  = 32;
  localparam int DIGIT = 4;
  localparam int NDIG  = XLEN / DIGIT;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            op_unsigned;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int vectors    = 0;
  int miscompares = 0;

  // Last result the model expects the DUT to be holding.
  logic [XLEN-1:0] held = '0;

  always #5 clk = ~clk;

  slt_sequencer #(
    .XLEN  (XLEN),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_unsigned (op_unsigned),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // Advance one clock; observe 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural less-than.
  function automatic logic ref_lt(input logic us, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (us) return (a < b);
    return ($signed(a) < $signed(b));
  endfunction

  // Reference: scan cycles = 1-based digit position (from MSB) of the highest differing bit.
  function automatic int ref_cycles(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] x;
    x = a ^ b;
    if (x == '0) return NDIG;
    for (int p = XLEN - 1; p >= 0; p--) begin
      if (x[p]) return NDIG - (p / DIGIT);
    end
    return NDIG;
  endfunction

  // Present a request for one cycle; returns observing cycle t+1.
  task automatic issue(input logic us, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    start       = 1'b1;
    op_unsigned = us;
    rs1         = a;
    rs2         = b;
    step();
    start = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  // From cycle t+1: expect k busy cycles holding the old result, then the done pulse.
  task automatic finish_op(input string tag, input logic us, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b);
    int k;
    k = ref_cycles(a, b);
    for (int c = 1; c <= k; c++) begin
      check({tag, " busy"}, {31'b0, busy}, 32'h1);
      check({tag, " done-early"}, {31'b0, done}, 32'h0);
      check({tag, " held"}, result, held);
      step();
    end
    held = {31'b0, ref_lt(us, a, b)};
    check({tag, " done"}, {31'b0, done}, 32'h1);
    check({tag, " busy-at-done"}, {31'b0, busy}, 32'h0);
    check({tag, " result"}, result, held);
  endtask

  task automatic run_op(input string tag, input logic us, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b);
    issue(us, a, b);
    finish_op(tag, us, a, b);
  endtask

  initial begin
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            us;
    int              gap;

    reset = 1'b1; start = 1'b0; op_unsigned = 1'b0; rs1 = '0; rs2 = '0;
    step();
    step();
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    step();
    check("idle done", {31'b0, done}, 32'h0);

    // Directed cases.
    run_op("u5lt7", 1'b1, 32'd5, 32'd7);
    step();
    check("idle after done", {31'b0, done | busy}, 32'h0);
    run_op("s-1lt1", 1'b0, 32'hFFFF_FFFF, 32'h1);
    run_op("uFFlt1", 1'b1, 32'hFFFF_FFFF, 32'h1);
    run_op("s-eq", 1'b0, 32'h1234_5678, 32'h1234_5678);
    run_op("u-eq", 1'b1, 32'h1234_5678, 32'h1234_5678);
    step();

    // Ignored start while busy, then back-to-back start from DONE.
    issue(1'b1, 32'h0, 32'h8000_0000);
    check("ign busy", {31'b0, busy}, 32'h1);
    start = 1'b1; op_unsigned = 1'b1; rs1 = 32'hFFFF_FFFF; rs2 = 32'h0;
    step();
    start = 1'b0;
    held = 32'h1;
    check("ign done", {31'b0, done}, 32'h1);
    check("ign result", result, 32'h1);
    issue(1'b0, 32'h7000_0000, 32'h7000_0001);
    check("b2b busy", {31'b0, busy}, 32'h1);
    check("b2b done", {31'b0, done}, 32'h0);
    finish_op("b2b", 1'b0, 32'h7000_0000, 32'h7000_0001);
    step();

    // Reset during the third scan cycle; result is 1 beforehand so clearing is visible.
    issue(1'b1, 32'd5, 32'd7);
    step();
    step();
    check("pre-rst busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    held = '0;
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    check("rst result", result, 32'h0);
    for (int c = 0; c < 12; c++) begin
      step();
      check("post-rst quiet", {31'b0, done | busy}, 32'h0);
    end

    // Randomized operations with varied first-difference position and idle gaps.
    for (int n = 0; n < 60; n++) begin
      us = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        default: b = a ^ (32'h1 << $urandom_range(0, XLEN - 1));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [XLEN-1:0] t;
        t = a; a = b; b = t;
      end
      run_op("rand", us, a, b);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check("rand gap", {31'b0, done | busy}, 32'h0);
        check("rand gap held", result, held);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slt_sequencer.md
# slt_sequencer

Multi-cycle compare sequencer for SLT, SLTI, SLTU and SLTIU in the RISC-V execute stage. It takes two 32-bit operands, with the immediate already muxed onto operand B upstream, and scans them MSB-first, DIGIT bits per cycle. It stops at the first differing digit and returns the 1-bit less-than flag zero-extended to 32 bits. A start/busy/done handshake lets the core stall on it, and it replaces the single-cycle 32-bit comparator on area-constrained builds.

## Interface
- XLEN, 32, operand and result width
- DIGIT, 4, bits compared per cycle; must divide XLEN (elaboration error otherwise)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op_unsigned  input  1  1 = SLTU/SLTIU, 0 = SLT/SLTI; captured with start
- rs1  input  XLEN  operand A; captured with start
- rs2  input  XLEN  operand B (register or sign-extended immediate); captured with start
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse; result valid from this cycle
- result  output  XLEN  {(XLEN-1)'b0, lt}; held until the next accepted start completes

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE or DONE with start=1:
  - capture rs1 and rs2 into a_q and b_q; for signed ops, invert bit XLEN-1 of both (maps two's complement onto unsigned order);
  - digit index idx_q = XLEN/DIGIT-1; go to SCAN.
- IDLE or DONE with start=0: go to IDLE.
- SCAN: compare digit idx_q of a_q and b_q, unsigned.
  - Digits differ: lt = (a_digit < b_digit); latch into the result register; go to DONE.
  - Digits equal and idx_q = 0: lt = 0; latch; go to DONE.
  - Otherwise: decrement idx_q; stay in SCAN.
- DONE: done=1 for exactly this cycle.
- start while busy=1 is ignored; there is no queueing.
- The result register changes only on the SCAN→DONE transition. Accepting a new start does not clear it.
- Reset (any state, including mid-SCAN): state=IDLE, busy=0, done=0, result=0, a_q=b_q=0, idx_q=0.

## Timing
- Start accepted at edge t. SCAN is active for cycles t+1 … t+k, where k is the 1-based position of the first differing digit counting from the MSB; k = XLEN/DIGIT if the operands are equal.
- done=1 and result valid at cycle t+k+1. Best case is t+2 (MSB digit differs); worst case is t+XLEN/DIGIT+1, which is t+9 with the defaults.
- busy = (state==SCAN), registered-state decode. busy is 0 in the start cycle and 1 from t+1.
- Back-to-back: start asserted in the DONE cycle is accepted, so the next SCAN begins the following cycle and no idle bubble is needed.
- All outputs are decoded from registered state; there is no combinational path from inputs to outputs.

## Structure
- Package slt_pkg holds:
  - the state_t enum (IDLE, SCAN, DONE);
  - localparams XLEN_DEF=32 and DIGIT_DEF=4;
  - the function digits(XLEN, DIGIT) = XLEN/DIGIT.
- One sub-module, digit_compare: purely combinational, DIGIT-bit unsigned compare. Outputs are eq and lt; it is instantiated once.
- Digit selection uses an indexed part-select on a_q/b_q with idx_q*DIGIT. idx_q width is $clog2(XLEN/DIGIT).

## Test plan
- Unsigned compare decided at the last digit: op_unsigned=1, rs1=5, rs2=7, start at t -> busy for t+1..t+8, done at t+9, result=32'h1.
- Signed vs unsigned decided at the MSB digit: rs1=32'hFFFF_FFFF, rs2=1.
  - op_unsigned=0 -> done at t+2, result=1 (-1 < 1).
  - op_unsigned=1 -> done at t+2, result=0.
- Equal operands: rs1=rs2=32'h1234_5678 (either signedness) -> done at t+9, result=0.
- Ignored and back-to-back starts: start with rs1=0, rs2=32'h8000_0000, op_unsigned=1 -> done at t+2, result=1.
  - start pulsed with other operands at t+1 while busy -> no effect on this operation.
  - start asserted in the DONE cycle -> accepted; busy=1 the next cycle.
- Reset mid-scan: reset=1 during the 3rd SCAN cycle -> next cycle busy=0, done=0, result=0.
  - No done pulse appears afterwards unless a new start is issued.
